// File: rtl/sys_bus_master.sv
// Request-to-peripheral-bus master: one outstanding load/store, lane strobes, data replication and load extension.
// Latency: accept -> SETUP -> ACCESS (1+ cycles) -> one-cycle response; no response backpressure.
// Optional ACCESS timeout abort when SYS_BUS_TIMEOUT_EN is defined.
module sys_bus_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    pclk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [1:0]              req_size,
    input  logic                    req_unsigned,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic [DATA_WIDTH-1:0]   pdata,
    input  logic [DATA_WIDTH-1:0]   prdata,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [DATA_WIDTH/8-1:0] pstb,
    input  logic                    pready,
    input  logic                    perr
);
    localparam int NB = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                  state, state_nxt;
    logic                    r_write;
    logic [1:0]              r_size;
    logic                    r_uns;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic                    bad_req;
    logic                    accept;
    logic                    tmo;
    logic [NB-1:0]           lanes;
    logic [DATA_WIDTH-1:0]   shifted;
    logic [DATA_WIDTH-1:0]   ld_ext;

    assign accept  = (state == IDLE) && req_valid;
    assign bad_req = (req_size == 2'd3) ||
                     ((req_size == 2'd1) && req_addr[0]) ||
                     ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));

`ifdef SYS_BUS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;

    // cnt holds the number of ACCESS cycles already elapsed, so the abort fires on the last allowed one
    assign tmo = (state == ACCESS) && (cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge pclk) begin
        if (rst)                   cnt <= '0;
        else if (state == SETUP)   cnt <= '0;
        else if (state == ACCESS)  cnt <= cnt + 1'b1;
    end
`else
    // No counter in this build; the parameter only shapes the interface
    assign tmo = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = bad_req ? RESP : SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (pready || tmo) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        lanes = '1;
        case (r_size)
            2'd0:    lanes = NB'(1) << r_addr[1:0];
            2'd1:    lanes = NB'(3) << r_addr[1:0];
            default: lanes = '1;
        endcase
    end

    always_comb begin
        pdata = r_wdata;
        case (r_size)
            2'd0:    pdata = {NB{r_wdata[7:0]}};
            2'd1:    pdata = {(NB/2){r_wdata[15:0]}};
            default: pdata = r_wdata;
        endcase
    end

    assign shifted = prdata >> {r_addr[1:0], 3'b000};

    always_comb begin
        ld_ext = shifted;
        case (r_size)
            2'd0:    ld_ext = r_uns ? {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]}
                                    : {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
            2'd1:    ld_ext = r_uns ? {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]}
                                    : {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
            default: ld_ext = shifted;
        endcase
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign psel      = (state == SETUP) || (state == ACCESS);
    assign penable   = (state == ACCESS);
    assign pwrite    = psel && r_write;
    assign pstb      = psel ? lanes : '0;
    assign paddr     = r_addr;

    always_ff @(posedge pclk) begin
        if (rst) begin
            state     <= IDLE;
            r_write   <= 1'b0;
            r_size    <= 2'd0;
            r_uns     <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                r_write   <= req_write;
                r_size    <= req_size;
                r_uns     <= req_unsigned;
                r_addr    <= req_addr;
                r_wdata   <= req_wdata;
                rsp_err   <= bad_req;
                rsp_rdata <= '0;
            end else if (state == ACCESS && pready) begin
                rsp_err   <= perr;
                rsp_rdata <= (perr || r_write) ? '0 : ld_ext;
            end else if (tmo) begin
                rsp_err   <= 1'b1;
                rsp_rdata <= '0;
            end
        end
    end
endmodule

// File: tb/tb_sys_bus_master.sv
// Directed bench for sys_bus_master: fixed-latency transactions with hand-computed bus and response values.
module tb_sys_bus_master;
    logic        pclk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata, paddr, pdata, prdata;
    logic        psel, penable, pwrite, pready, perr;
    logic [3:0]  pstb;

    int checks   = 0;
    int failures = 0;

    sys_bus_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
        .pclk(pclk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .paddr(paddr), .pdata(pdata), .prdata(prdata),
        .psel(psel), .penable(penable), .pwrite(pwrite), .pstb(pstb),
        .pready(pready), .perr(perr)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Drives one request and checks every cycle against a responder with 'waits' wait states.
    task automatic txn(input string name, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd, input int waits,
                       input logic perr_in, input logic [31:0] rd, input logic mis,
                       input logic [3:0] exp_stb, input logic [31:0] exp_pdata,
                       input logic [31:0] exp_rdata, input logic exp_err);
        @(negedge pclk);
        chk({name, ".req_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd; pready = 1'b0; perr = 1'b0;
        @(negedge pclk);
        req_valid = 1'b0;
        if (mis) begin
            chk({name, ".mis_psel"}, 32'(psel), 32'd0);
            chk({name, ".mis_rsp_valid"}, 32'(rsp_valid), 32'd1);
            chk({name, ".mis_rsp_err"}, 32'(rsp_err), 32'd1);
            chk({name, ".mis_rsp_rdata"}, rsp_rdata, 32'd0);
        end else begin
            chk({name, ".setup_psel"}, 32'(psel), 32'd1);
            chk({name, ".setup_penable"}, 32'(penable), 32'd0);
            chk({name, ".setup_pwrite"}, 32'(pwrite), 32'(wr));
            chk({name, ".setup_pstb"}, 32'(pstb), 32'(exp_stb));
            chk({name, ".setup_paddr"}, paddr, addr);
            if (wr) chk({name, ".setup_pdata"}, pdata, exp_pdata);
            pready = 1'b1; perr = 1'b1;     // must be ignored outside ACCESS
            for (int w = 0; w <= waits; w++) begin
                @(negedge pclk);
                chk({name, ".acc_psel"}, 32'(psel), 32'd1);
                chk({name, ".acc_penable"}, 32'(penable), 32'd1);
                chk({name, ".acc_pstb"}, 32'(pstb), 32'(exp_stb));
                chk({name, ".acc_paddr"}, paddr, addr);
                chk({name, ".acc_rsp_valid"}, 32'(rsp_valid), 32'd0);
                pready = (w == waits);
                perr   = (w == waits) ? perr_in : 1'b0;
                prdata = rd;
            end
            @(negedge pclk);
            pready = 1'b0; perr = 1'b0;
            chk({name, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
            chk({name, ".rsp_rdata"}, rsp_rdata, exp_rdata);
            chk({name, ".rsp_err"}, 32'(rsp_err), 32'(exp_err));
            chk({name, ".rsp_psel"}, 32'(psel), 32'd0);
            chk({name, ".rsp_pstb"}, 32'(pstb), 32'd0);
        end
        @(negedge pclk);
        chk({name, ".done_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({name, ".done_req_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; prdata = 32'h0; pready = 1'b0; perr = 1'b0;
        repeat (2) @(negedge pclk);
        chk("rst.psel", 32'(psel), 32'd0);
        chk("rst.penable", 32'(penable), 32'd0);
        chk("rst.pwrite", 32'(pwrite), 32'd0);
        chk("rst.pstb", 32'(pstb), 32'd0);
        chk("rst.paddr", paddr, 32'd0);
        chk("rst.pdata", pdata, 32'd0);
        chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst.rsp_err", 32'(rsp_err), 32'd0);
        chk("rst.rsp_rdata", rsp_rdata, 32'd0);
        rst = 1'b0;

        //   name       wr  sz    uns   addr          wdata         waits perr  prdata        mis   stb      pdata         rdata         err
        txn("st_word",  1, 2'd2, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 1, 1'b0, 32'h0,        1'b0, 4'hF,    32'hDEAD_BEEF, 32'h0,        1'b0);
        txn("ld_word",  0, 2'd2, 1'b0, 32'h0000_0100, 32'h0,        1, 1'b0, 32'hDEAD_BEEF, 1'b0, 4'hF,    32'h0,        32'hDEAD_BEEF, 1'b0);
        txn("st_byte",  1, 2'd0, 1'b0, 32'h0000_0103, 32'h0000_0080, 0, 1'b0, 32'h0,        1'b0, 4'b1000, 32'h8080_8080, 32'h0,        1'b0);
        txn("ld_sbyte", 0, 2'd0, 1'b0, 32'h0000_0103, 32'h0,        0, 1'b0, 32'h8012_3456, 1'b0, 4'b1000, 32'h0,        32'hFFFF_FF80, 1'b0);
        txn("ld_ubyte", 0, 2'd0, 1'b1, 32'h0000_0103, 32'h0,        2, 1'b0, 32'h8012_3456, 1'b0, 4'b1000, 32'h0,        32'h0000_0080, 1'b0);
        txn("ld_b1",    0, 2'd0, 1'b0, 32'h0000_0101, 32'h0,        0, 1'b0, 32'h1122_7F44, 1'b0, 4'b0010, 32'h0,        32'h0000_007F, 1'b0);
        txn("st_half",  1, 2'd1, 1'b0, 32'h0000_0002, 32'h1234_ABCD, 0, 1'b0, 32'h0,        1'b0, 4'b1100, 32'hABCD_ABCD, 32'h0,        1'b0);
        txn("ld_shalf", 0, 2'd1, 1'b0, 32'h0000_0102, 32'h0,        1, 1'b0, 32'hBEEF_1234, 1'b0, 4'b1100, 32'h0,        32'hFFFF_BEEF, 1'b0);
        txn("ld_uhalf", 0, 2'd1, 1'b1, 32'h0000_0100, 32'h0,        0, 1'b0, 32'hBEEF_9234, 1'b0, 4'b0011, 32'h0,        32'h0000_9234, 1'b0);
        txn("mis_word", 0, 2'd2, 1'b0, 32'h0000_0102, 32'h0,        0, 1'b0, 32'h0,        1'b1, 4'h0,    32'h0,        32'h0,        1'b1);
        txn("mis_half", 1, 2'd1, 1'b0, 32'h0000_0101, 32'h0,        0, 1'b0, 32'h0,        1'b1, 4'h0,    32'h0,        32'h0,        1'b1);
        txn("size3",    0, 2'd3, 1'b0, 32'h0000_0100, 32'h0,        0, 1'b0, 32'h0,        1'b1, 4'h0,    32'h0,        32'h0,        1'b1);
        txn("perr",     0, 2'd2, 1'b0, 32'h0000_0104, 32'h0,        1, 1'b1, 32'h1234_5678, 1'b0, 4'hF,    32'h0,        32'h0,        1'b1);

        // Reset pulsed during ACCESS abandons the transfer
        @(negedge pclk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 32'h0000_0200;
        @(negedge pclk);
        req_valid = 1'b0;
        @(negedge pclk);
        chk("rstmid.penable", 32'(penable), 32'd1);
        rst = 1'b1;
        @(negedge pclk);
        chk("rstmid.psel", 32'(psel), 32'd0);
        chk("rstmid.rsp_valid", 32'(rsp_valid), 32'd0);
        rst = 1'b0; pready = 1'b1;
        @(negedge pclk);
        chk("rstmid.req_ready", 32'(req_ready), 32'd1);
        chk("rstmid.no_rsp", 32'(rsp_valid), 32'd0);
        chk("rstmid.psel_idle", 32'(psel), 32'd0);
        pready = 1'b0;
        txn("post_rst", 0, 2'd2, 1'b0, 32'h0000_0200, 32'h0, 0, 1'b0, 32'hCAFE_F00D, 1'b0, 4'hF, 32'h0, 32'hCAFE_F00D, 1'b0);

`ifdef SYS_BUS_TIMEOUT_EN
        @(negedge pclk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 32'h0000_0300;
        prdata = 32'h5555_AAAA; pready = 1'b0;
        @(negedge pclk);
        req_valid = 1'b0;
        chk("tmo.setup_psel", 32'(psel), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge pclk);
            chk("tmo.acc_penable", 32'(penable), 32'd1);
            chk("tmo.acc_no_rsp", 32'(rsp_valid), 32'd0);
        end
        @(negedge pclk);
        chk("tmo.rsp_valid", 32'(rsp_valid), 32'd1);
        chk("tmo.rsp_err", 32'(rsp_err), 32'd1);
        chk("tmo.rsp_rdata", rsp_rdata, 32'd0);
        chk("tmo.psel", 32'(psel), 32'd0);
        @(negedge pclk);
        chk("tmo.idle", 32'(req_ready), 32'd1);
        chk("tmo.rsp_off", 32'(rsp_valid), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sys_bus_master.md
SYS_BUS_MASTER -- requirements
Module: sys_bus_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, bus address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, bus data width; pstb is DATA_WIDTH/8 bits.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum ACCESS-phase cycles before abort.
REQ-004 SHALL have ports:
- pclk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when high with req_valid.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data, right-aligned.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors.
- rsp_err  out  1  error flag, valid with rsp_valid.
- paddr  out  ADDR_WIDTH  bus address.
- pdata  out  DATA_WIDTH  bus write data.
- prdata  in  DATA_WIDTH  bus read data.
- psel, penable, pwrite  out  1 each  bus controls.
- pstb  out  4  byte-lane strobes.
- pready, perr  in  1 each  responder completion and error.

Function
REQ-005 SHALL implement the states IDLE, SETUP, ACCESS and RESP.
REQ-006 SHALL assert req_ready only in IDLE; req_valid&&req_ready latches all req_* fields and moves IDLE->SETUP.
REQ-007 SHALL raise rsp_err in RESP without a bus access when the request is misaligned (half with addr[0]=1, word with addr[1:0]!=0) or has req_size=3 (IDLE->RESP).
REQ-008 SHALL drive psel=1, penable=0 in SETUP for exactly one cycle, then go to ACCESS.
REQ-009 SHALL drive psel=1, penable=1 in ACCESS, holding paddr/pdata/pwrite/pstb stable from SETUP until exit.
REQ-010 SHALL, in ACCESS with pready=1, register prdata and perr and move to RESP.
REQ-011 SHALL assert rsp_valid for exactly one cycle in RESP, with psel=penable=0, then return to IDLE; rsp_valid has no backpressure.
REQ-012 SHALL drive psel, penable, pwrite and pstb to 0 in IDLE and RESP.
REQ-013 SHALL drive paddr with the full latched address, low bits unmasked.
REQ-014 SHALL set pstb to 4'b0001<<addr[1:0] for byte, 4'b0011<<addr[1:0] for half and 4'b1111 for word, on both loads and stores.
REQ-015 SHALL replicate store data on pdata: byte 4x, half 2x, word as-is.
REQ-016 SHALL form the load result as prdata>>(8*addr[1:0]), truncate it to the size, and zero- or sign-extend it per req_unsigned.
REQ-017 SHALL set rsp_err=perr as registered; on error rsp_rdata=0.
REQ-018 SHALL give minimum latency against a one-wait responder as follows: accept at edge 0, SETUP cycle 1, ACCESS cycles 2-3, rsp_valid cycle 4.
REQ-019 SHALL ignore pready and perr outside ACCESS.

Reset
REQ-020 SHALL, while rst=1, force state IDLE, psel=penable=pwrite=0, pstb=0, paddr=0, pdata=0, rsp_valid=0, rsp_err=0, rsp_rdata=0 and timeout counter 0.
REQ-021 SHALL abandon the transaction on rst mid-transaction: psel drops at the next edge and no rsp_valid is produced; req_ready=1 on the first cycle after rst is released.

Configuration
REQ-022 SHALL, with macro SYS_BUS_TIMEOUT_EN defined, count ACCESS cycles; if the count reaches TIMEOUT_CYCLES with pready=0, go to RESP with rsp_err=1 and rsp_rdata=0, and clear the counter on ACCESS entry.
REQ-023 SHALL, without SYS_BUS_TIMEOUT_EN, omit the counter and wait in ACCESS indefinitely for pready.

Verification
REQ-024 SHALL cover a word store then load: store 0xDEADBEEF to 0x100, then load 0x100 -> pstb=4'hF on the store, rsp_rdata=0xDEADBEEF, rsp_err=0, and rsp_valid 4 cycles after acceptance.
REQ-025 SHALL cover byte lanes: store byte 0x80 to 0x103 -> pstb=4'b1000 and pdata=0x80808080; signed load of the byte at 0x103 -> 0xFFFFFF80; unsigned load -> 0x00000080.
REQ-026 SHALL cover a misaligned access: word load at 0x102 -> psel never asserts, and rsp_valid with rsp_err=1 and rsp_rdata=0 one cycle after acceptance.
REQ-027 SHALL cover a responder error: perr=1 with pready -> rsp_err=1 and rsp_rdata=0.
REQ-028 SHALL cover the timeout: with SYS_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4 and pready held 0 -> exactly 4 ACCESS cycles, then rsp_err=1, then IDLE.
REQ-029 SHALL cover reset mid-ACCESS: rst pulsed for one cycle -> psel=0 the next cycle, no rsp_valid, and a fresh request then completes normally.
